// File: rtl/date_counter.sv
// Calendar date register (day/month/year) with a carry input from the hour counter
// and button-driven manual adjustment. Inputs act on their falling edges.
module date_counter #(
    parameter int YEAR_MIN = 2000,
    parameter int YEAR_MAX = 2099
) (
    input  logic        i_clk_0_001s,
    input  logic        reset,
    input  logic [4:0]  state,
    input  logic        is_modify,
    input  logic        i_plus,
    input  logic        i_minus,
    input  logic        i_enable,
    output logic [4:0]  o_day,
    output logic [3:0]  o_month,
    output logic [13:0] o_year,
    output logic        o_leap
);

    localparam logic [13:0] YMIN = 14'(YEAR_MIN);
    localparam logic [13:0] YMAX = 14'(YEAR_MAX);

    logic       prev_en, prev_plus, prev_minus;
    logic       f_en, f_plus, f_minus;
    logic [4:0] nd;
    logic [3:0] nm;
    logic [13:0] ny;
    logic [4:0] cur_dim, new_dim;
    logic       up;

    function automatic logic [4:0] dim_of(input logic [3:0] m, input logic leap);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: dim_of = 5'd30;
            4'd2:                    dim_of = leap ? 5'd29 : 5'd28;
            default:                 dim_of = 5'd31;
        endcase
    endfunction

    assign o_leap  = (o_year[1:0] == 2'd0);
    assign cur_dim = dim_of(o_month, o_leap);
    assign new_dim = dim_of(nm, ny[1:0] == 2'd0);

    // Carry beats minus beats plus; losers in the same cycle are dropped.
    always_comb begin
        nd = o_day;
        nm = o_month;
        ny = o_year;
        up = !f_minus;
        if (f_en) begin
            if (o_day < cur_dim) begin
                nd = o_day + 5'd1;
            end else begin
                nd = 5'd1;
                if (o_month == 4'd12) begin
                    nm = 4'd1;
                    ny = (o_year == YMAX) ? YMIN : o_year + 14'd1;
                end else begin
                    nm = o_month + 4'd1;
                end
            end
        end else if (is_modify && (f_minus || f_plus)) begin
            case (state)
                5'd1: begin
                    if (up) nd = (o_day >= cur_dim) ? 5'd1 : o_day + 5'd1;
                    else    nd = (o_day <= 5'd1) ? cur_dim : o_day - 5'd1;
                end
                5'd2: begin
                    if (up) nm = (o_month >= 4'd12) ? 4'd1 : o_month + 4'd1;
                    else    nm = (o_month <= 4'd1) ? 4'd12 : o_month - 4'd1;
                end
                5'd3: begin
                    if (up) ny = (o_year >= YMAX) ? YMIN : o_year + 14'd1;
                    else    ny = (o_year <= YMIN) ? YMAX : o_year - 14'd1;
                end
                default: ;
            endcase
            // Month/year change can shrink the month below the current day.
            if (nd > new_dim) nd = new_dim;
        end
    end

    always_ff @(posedge i_clk_0_001s or negedge reset) begin
        if (!reset) begin
            prev_en    <= 1'b0;
            prev_plus  <= 1'b0;
            prev_minus <= 1'b0;
            f_en       <= 1'b0;
            f_plus     <= 1'b0;
            f_minus    <= 1'b0;
            o_day      <= 5'd1;
            o_month    <= 4'd1;
            o_year     <= YMIN;
        end else begin
            prev_en    <= i_enable;
            prev_plus  <= i_plus;
            prev_minus <= i_minus;
            f_en       <= prev_en & ~i_enable;
            f_plus     <= prev_plus & ~i_plus;
            f_minus    <= prev_minus & ~i_minus;
            o_day      <= nd;
            o_month    <= nm;
            o_year     <= ny;
        end
    end

endmodule

// File: tb/tb_date_counter.sv
// Directed bench for date_counter: carries, leap handling, adjust wraps, clamping,
// gating, event priority and reset behaviour.
module tb_date_counter;

    logic        clk;
    logic        reset;
    logic [4:0]  state;
    logic        is_modify;
    logic        i_plus, i_minus, i_enable;
    logic [4:0]  o_day;
    logic [3:0]  o_month;
    logic [13:0] o_year;
    logic        o_leap;

    int checks = 0;
    int errors = 0;

    date_counter dut (
        .i_clk_0_001s(clk),
        .reset(reset),
        .state(state),
        .is_modify(is_modify),
        .i_plus(i_plus),
        .i_minus(i_minus),
        .i_enable(i_enable),
        .o_day(o_day),
        .o_month(o_month),
        .o_year(o_year),
        .o_leap(o_leap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_date(input string tag, input int d, input int m, input int y);
        chk({tag, " day"}, 32'(o_day), 32'(d));
        chk({tag, " month"}, 32'(o_month), 32'(m));
        chk({tag, " year"}, 32'(o_year), 32'(y));
    endtask

    // which: 0 = enable, 1 = minus, 2 = plus, 3 = all three together
    task automatic press(input int which);
        @(negedge clk);
        if (which == 0 || which == 3) i_enable = 1'b1;
        if (which == 1 || which == 3) i_minus  = 1'b1;
        if (which == 2 || which == 3) i_plus   = 1'b1;
        @(negedge clk);
        i_enable = 1'b0;
        i_minus  = 1'b0;
        i_plus   = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    function automatic int field(input int st);
        if (st == 1) return int'(o_day);
        if (st == 2) return int'(o_month);
        return int'(o_year);
    endfunction

    task automatic set_field(input int st, input int target);
        int n;
        is_modify = 1'b1;
        state = 5'(st);
        n = 0;
        while (field(st) != target && n < 130) begin
            press(2);
            n++;
        end
        if (field(st) != target) begin
            checks++;
            errors++;
            $display("FAIL set_field%0d observed %0d expected %0d", st, field(st), target);
        end
    endtask

    task automatic goto(input int y, input int m, input int d);
        set_field(3, y);
        set_field(2, m);
        set_field(1, d);
    endtask

    initial begin
        reset = 1'b0; state = 5'd0; is_modify = 1'b0;
        i_plus = 1'b0; i_minus = 1'b0; i_enable = 1'b0;
        repeat (2) @(negedge clk);
        chk_date("reset", 1, 1, 2000);
        chk("reset leap", 32'(o_leap), 32'd1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_date("idle after reset", 1, 1, 2000);

        // Year minus wraps to the top of the range
        is_modify = 1'b1; state = 5'd3;
        press(1);
        chk_date("year wrap down", 1, 1, 2099);
        press(2);
        chk_date("year wrap up", 1, 1, 2000);

        // Year-end carry with exact latency
        goto(2099, 12, 31);
        chk("2099 leap", 32'(o_leap), 32'd0);
        is_modify = 1'b0;
        @(negedge clk); i_enable = 1'b1;
        @(negedge clk); i_enable = 1'b0;
        @(negedge clk);
        chk_date("carry latency hold", 31, 12, 2099);
        @(negedge clk);
        chk_date("carry year end", 1, 1, 2000);
        chk("carry leap", 32'(o_leap), 32'd1);

        // Leap February
        goto(2024, 2, 28);
        press(0);
        chk_date("leap feb 29", 29, 2, 2024);
        press(0);
        chk_date("leap mar 1", 1, 3, 2024);
        goto(2023, 2, 28);
        press(0);
        chk_date("nonleap mar 1", 1, 3, 2023);

        // Clamp on month change
        goto(2023, 3, 31);
        state = 5'd2;
        press(1);
        chk_date("clamp minus month", 28, 2, 2023);
        press(2);
        chk_date("plus month no restore", 28, 3, 2023);

        // Clamp on year change out of a leap February
        goto(2024, 2, 29);
        state = 5'd3;
        press(2);
        chk_date("clamp plus year", 28, 2, 2025);

        // Day wraps inside a 30-day month, month wraps at the ends
        goto(2023, 4, 30);
        press(2);
        chk_date("day wrap up", 1, 4, 2023);
        press(1);
        chk_date("day wrap down", 30, 4, 2023);
        goto(2023, 12, 5);
        state = 5'd2;
        press(2);
        chk_date("month wrap up", 5, 1, 2023);
        press(1);
        chk_date("month wrap down", 5, 12, 2023);

        // Gating: adjust ignored outside modify mode or with no field selected
        is_modify = 1'b0; state = 5'd1;
        press(2);
        chk_date("gate modify off", 5, 12, 2023);
        is_modify = 1'b1; state = 5'd0;
        press(2);
        chk_date("gate state 0", 5, 12, 2023);
        state = 5'd4;
        press(1);
        chk_date("gate state 4", 5, 12, 2023);

        // Simultaneous events: carry wins, others dropped
        goto(2023, 6, 30);
        state = 5'd1;
        press(3);
        chk_date("simultaneous", 1, 7, 2023);
        repeat (4) @(negedge clk);
        chk_date("hold idle", 1, 7, 2023);

        // Reset with a plus flag in flight
        @(negedge clk); i_plus = 1'b1;
        @(negedge clk); i_plus = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_date("async reset", 1, 1, 2000);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk_date("no action after release", 1, 1, 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
